// File: rtl/pipe_l1a_extract_if.sv
// Bundle of the L1A extractor's pipeline, trigger, release and sample-buffer signals.
// L1A, BLK_RLS, EVT_RDY, L1A_LOST and RLS_ERR are single-cycle pulses with no back-pressure; PIPE_VLD qualifies PIPOUT on the same cycle.
interface pipe_l1a_extract_if #(
  parameter int DW     = 192,
  parameter int BLK_W  = 2,
  parameter int LOST_W = 16
);
  logic              L1A;
  logic              PIPE_VLD;
  logic [DW-1:0]     PIPOUT;
  logic [4:0]        NSAMP;
  logic              BLK_RLS;
  logic              SMP_WE;
  logic [BLK_W+3:0]  SMP_ADDR;
  logic [DW-1:0]     SMP_DATA;
  logic              EVT_RDY;
  logic [BLK_W-1:0]  EVT_BLK;
  logic              BUSY;
  logic              BLK_FULL;
  logic              L1A_LOST;
  logic [LOST_W-1:0] LOST_CNT;
  logic              RLS_ERR;
  logic              STATE;

  modport master (
    output L1A, PIPE_VLD, PIPOUT, NSAMP, BLK_RLS,
    input  SMP_WE, SMP_ADDR, SMP_DATA, EVT_RDY, EVT_BLK, BUSY, BLK_FULL,
           L1A_LOST, LOST_CNT, RLS_ERR, STATE
  );

  modport slave (
    input  L1A, PIPE_VLD, PIPOUT, NSAMP, BLK_RLS,
    output SMP_WE, SMP_ADDR, SMP_DATA, EVT_RDY, EVT_BLK, BUSY, BLK_FULL,
           L1A_LOST, LOST_CNT, RLS_ERR, STATE
  );
endinterface

// File: rtl/pipe_l1a_extract.sv
// Captures NSAMP pipeline words per accepted L1A into a ring of sample blocks,
// announces completed events and tracks block occupancy against downstream releases.
module pipe_l1a_extract #(
  parameter int DW     = 192,
  parameter int BLK_W  = 2,
  parameter int LOST_W = 16
) (
  input  logic CLK,
  input  logic RST_N,
  pipe_l1a_extract_if.slave bus
);

  localparam int NBLK = 1 << BLK_W;
  localparam logic [BLK_W:0] OCC_FULL = (BLK_W+1)'(NBLK);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CAPT = 1'b1;

  logic [0:0]       state, state_next;
  logic [BLK_W-1:0] wblk;
  logic [BLK_W:0]   occ, occ_next;
  logic [3:0]       k, last_k, nsamp_last, cur_k;
  logic             accept, rls_ok, capt_now, last_now;

  assign bus.STATE = state[0];

  always_comb begin
    // 0 and anything above 16 both mean a full 16-word event
    nsamp_last = (bus.NSAMP == 5'd0 || bus.NSAMP > 5'd16) ? 4'd15 : 4'(bus.NSAMP - 5'd1);
    accept     = (state == IDLE) && bus.L1A && bus.PIPE_VLD && (occ != OCC_FULL);
    rls_ok     = bus.BLK_RLS && (occ != '0);
    occ_next   = occ;
    if (accept && !rls_ok)      occ_next = occ + 1'b1;
    else if (!accept && rls_ok) occ_next = occ - 1'b1;
    capt_now   = accept || ((state == CAPT) && bus.PIPE_VLD);
    cur_k      = (state == CAPT) ? k : 4'd0;
    last_now   = capt_now && (cur_k == ((state == CAPT) ? last_k : nsamp_last));
    state_next = state;
    if (last_now)    state_next = IDLE;
    else if (accept) state_next = CAPT;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      wblk         <= '0;
      occ          <= '0;
      k            <= '0;
      last_k       <= 4'd15;
      bus.SMP_WE   <= 1'b0;
      bus.SMP_ADDR <= '0;
      bus.SMP_DATA <= '0;
      bus.EVT_RDY  <= 1'b0;
      bus.EVT_BLK  <= '0;
      bus.BUSY     <= 1'b0;
      bus.BLK_FULL <= 1'b0;
      bus.L1A_LOST <= 1'b0;
      bus.LOST_CNT <= '0;
      bus.RLS_ERR  <= 1'b0;
    end else begin
      state        <= state_next;
      occ          <= occ_next;
      bus.BLK_FULL <= (occ_next == OCC_FULL);
      bus.BUSY     <= (state == CAPT) || (state_next == CAPT);
      bus.SMP_WE   <= capt_now;
      bus.EVT_RDY  <= last_now;
      bus.RLS_ERR  <= bus.BLK_RLS && (occ == '0);
      bus.L1A_LOST <= bus.L1A && !accept;

      if (capt_now) begin
        bus.SMP_ADDR <= {wblk, cur_k};
        bus.SMP_DATA <= bus.PIPOUT;
      end
      if (last_now) begin
        bus.EVT_BLK <= wblk;
        wblk        <= wblk + 1'b1;
      end
      // NSAMP is sampled only at acceptance so mid-event changes cannot shorten it
      if (accept) begin
        last_k <= nsamp_last;
        k      <= 4'd1;
      end else if ((state == CAPT) && bus.PIPE_VLD) begin
        k <= k + 1'b1;
      end
      if (bus.L1A && !accept && (bus.LOST_CNT != '1))
        bus.LOST_CNT <= bus.LOST_CNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_l1a_extract.sv
// Directed bench for pipe_l1a_extract: stimulus pushes expected buffer writes,
// a negedge monitor pops and compares them, per-cycle checks cover status outputs.
module tb_pipe_l1a_extract;
  localparam int DW     = 192;
  localparam int BLK_W  = 2;
  localparam int LOST_W = 16;
  localparam int AW     = BLK_W + 4;
  localparam int EW     = 1 + BLK_W + AW + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [EW-1:0] exp_q[$];
  int   d2[8] = '{10, 11, 12, 15, 16, 17, 18, 19};

  pipe_l1a_extract_if #(.DW(DW), .BLK_W(BLK_W), .LOST_W(LOST_W)) bus ();

  pipe_l1a_extract #(.DW(DW), .BLK_W(BLK_W), .LOST_W(LOST_W)) dut (
    .CLK(clk), .RST_N(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int c);
    logic [31:0] w;
    w = c;
    pat = {w ^ 32'hF0F0_0006, w ^ 32'h0F0F_0005, w ^ 32'hA5A5_0004,
           w ^ 32'h5A5A_0003, w ^ 32'h3C3C_0002, w};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_w(input int addr, input int c, input bit evt, input int blk);
    logic [BLK_W-1:0] b;
    b = evt ? BLK_W'(blk) : '0;
    exp_q.push_back({evt, b, AW'(addr), pat(c)});
  endtask

  task automatic cycle(input bit l1a, input bit vld, input bit rls, input int c);
    bus.L1A      = l1a;
    bus.PIPE_VLD = vld;
    bus.BLK_RLS  = rls;
    bus.PIPOUT   = pat(c);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"},   bus.SMP_WE,   0);
    chk({tag, "_addr"}, bus.SMP_ADDR, 0);
    chk({tag, "_data"}, bus.SMP_DATA, 0);
    chk({tag, "_evt"},  bus.EVT_RDY,  0);
    chk({tag, "_eblk"}, bus.EVT_BLK,  0);
    chk({tag, "_busy"}, bus.BUSY,     0);
    chk({tag, "_full"}, bus.BLK_FULL, 0);
    chk({tag, "_lost"}, bus.L1A_LOST, 0);
    chk({tag, "_lcnt"}, bus.LOST_CNT, 0);
    chk({tag, "_rerr"}, bus.RLS_ERR,  0);
    chk({tag, "_st"},   bus.STATE,    0);
  endtask

  task automatic do_reset(input bit check);
    bus.L1A = 1'b0; bus.PIPE_VLD = 1'b0; bus.BLK_RLS = 1'b0;
    bus.PIPOUT = '0; bus.NSAMP = 5'd8;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (check) chk_zero("reset");
    rst_n = 1'b1;
  endtask

  // Monitor: every write or event pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && (bus.SMP_WE || bus.EVT_RDY)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h evt %0b with nothing expected",
                 bus.SMP_ADDR, bus.EVT_RDY);
      end else begin
        logic [EW-1:0] e, a;
        e = exp_q.pop_front();
        a = {bus.EVT_RDY, bus.EVT_RDY ? bus.EVT_BLK : {BLK_W{1'b0}}, bus.SMP_ADDR, bus.SMP_DATA};
        if (a !== e) begin
          n_bad++;
          $display("FAIL write: got %0h expected %0h", a, e);
        end
      end
    end
  end

  initial begin
    do_reset(1'b1);

    // basic 8-sample event, continuous valid
    do_reset(1'b0);
    bus.NSAMP = 5'd8;
    for (int c = 0; c <= 22; c++) begin
      if (c == 10) for (int k = 0; k < 8; k++) push_w(k, 10 + k, k == 7, 0);
      cycle(c == 10, 1'b1, 1'b0, c);
      chk($sformatf("t1_we@%0d", c),   bus.SMP_WE,  c >= 10 && c <= 17);
      chk($sformatf("t1_busy@%0d", c), bus.BUSY,    c >= 10 && c <= 17);
      chk($sformatf("t1_evt@%0d", c),  bus.EVT_RDY, c == 17);
    end
    chk("t1_drain", exp_q.size(), 0);

    // valid gaps are skipped
    do_reset(1'b0);
    bus.NSAMP = 5'd8;
    for (int c = 0; c <= 24; c++) begin
      if (c == 10) for (int k = 0; k < 8; k++) push_w(k, d2[k], k == 7, 0);
      cycle(c == 10, !(c == 13 || c == 14), 1'b0, c);
      chk($sformatf("t2_we@%0d", c), bus.SMP_WE,
          (c >= 10 && c <= 12) || (c >= 15 && c <= 19));
      chk($sformatf("t2_evt@%0d", c), bus.EVT_RDY, c == 19);
    end
    chk("t2_drain", exp_q.size(), 0);

    // L1A on last capture rejected, next cycle accepted into block 1
    do_reset(1'b0);
    bus.NSAMP = 5'd4;
    for (int c = 0; c <= 20; c++) begin
      if (c == 10) for (int k = 0; k < 4; k++) push_w(k, 10 + k, k == 3, 0);
      if (c == 14) for (int k = 0; k < 4; k++) push_w(16 + k, 14 + k, k == 3, 1);
      cycle(c == 10 || c == 13 || c == 14, 1'b1, 1'b0, c);
      chk($sformatf("t3_lost@%0d", c), bus.L1A_LOST, c == 13);
      chk($sformatf("t3_busy@%0d", c), bus.BUSY, c >= 10 && c <= 17);
    end
    chk("t3_lcnt", bus.LOST_CNT, 1);
    chk("t3_eblk", bus.EVT_BLK, 1);
    chk("t3_drain", exp_q.size(), 0);

    // fill all blocks, reject when full, release and wrap
    do_reset(1'b0);
    bus.NSAMP = 5'd1;
    for (int c = 0; c <= 18; c++) begin
      case (c)
        0:  push_w(8'h00, 0, 1, 0);
        2:  push_w(8'h10, 2, 1, 1);
        4:  push_w(8'h20, 4, 1, 2);
        6:  push_w(8'h30, 6, 1, 3);
        12: push_w(8'h00, 12, 1, 0);
        16: push_w(8'h10, 16, 1, 1);
        default: ;
      endcase
      cycle(c % 2 == 0 && c != 10 && c != 18, 1'b1, c == 10 || c == 14, c);
      chk($sformatf("t4_full@%0d", c), bus.BLK_FULL,
          (c >= 6 && c < 10) || (c >= 12 && c < 14) || c >= 16);
      chk($sformatf("t4_lost@%0d", c), bus.L1A_LOST, c == 8 || c == 14);
      chk($sformatf("t4_busy@%0d", c), bus.BUSY, 0);
    end
    chk("t4_lcnt", bus.LOST_CNT, 2);
    chk("t4_drain", exp_q.size(), 0);

    // release at zero occupancy, accept plus release at occupancy 2
    do_reset(1'b0);
    bus.NSAMP = 5'd1;
    for (int c = 0; c <= 14; c++) begin
      case (c)
        4:  push_w(8'h00, 4, 1, 0);
        6:  push_w(8'h10, 6, 1, 1);
        8:  push_w(8'h20, 8, 1, 2);
        10: push_w(8'h30, 10, 1, 3);
        12: push_w(8'h00, 12, 1, 0);
        default: ;
      endcase
      cycle(c >= 4 && c <= 12 && c % 2 == 0, 1'b1, c == 2 || c == 8, c);
      chk($sformatf("t5_rerr@%0d", c), bus.RLS_ERR, c == 2);
      chk($sformatf("t5_full@%0d", c), bus.BLK_FULL, c >= 12);
    end
    chk("t5_drain", exp_q.size(), 0);

    // NSAMP=0 means 16 samples; mid-event NSAMP change ignored
    do_reset(1'b0);
    bus.NSAMP = 5'd0;
    for (int c = 0; c <= 20; c++) begin
      if (c == 1) for (int k = 0; k < 16; k++) push_w(k, 1 + k, k == 15, 0);
      if (c == 5) bus.NSAMP = 5'd3;
      cycle(c == 1, 1'b1, 1'b0, c);
      chk($sformatf("t6_evt@%0d", c), bus.EVT_RDY, c == 16);
      chk($sformatf("t6_busy@%0d", c), bus.BUSY, c >= 1 && c <= 16);
    end
    chk("t6_drain", exp_q.size(), 0);

    // reset mid-capture aborts the event; next event starts at block 0
    do_reset(1'b0);
    bus.NSAMP = 5'd8;
    push_w(0, 1, 0, 0);
    push_w(1, 2, 0, 0);
    for (int c = 0; c <= 3; c++) cycle(c == 1, 1'b1, 1'b0, c);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("t7_async");
    do_reset(1'b0);
    chk("t7_drain_abort", exp_q.size(), 0);
    bus.NSAMP = 5'd2;
    for (int c = 0; c <= 6; c++) begin
      if (c == 1) begin
        push_w(0, 1, 0, 0);
        push_w(1, 2, 1, 0);
      end
      cycle(c == 1, 1'b1, 1'b0, c);
      chk($sformatf("t7_evt@%0d", c), bus.EVT_RDY, c == 2);
    end
    chk("t7_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
